// File: rtl/ps2_keycode_decoder.sv
// ps2_keycode_decoder
//   Turns the scan code set 2 byte stream from the PS/2 receiver into single
//   key events. Prefix bytes are stripped: E0 marks an extended key, F0 marks a
//   break, and the E1 pause sequence is collapsed into one event. The block
//   also tracks modifier keys and caps lock, and it presents one event at a
//   time to the CPU side.
//
// Handshakes:
//   Input  : in_ack is a registered one-cycle pulse. in_data is captured on
//            the edge that raises it. A two-cycle hold-off follows each pulse
//            so the receiver has time to drop in_valid. Bytes are taken only
//            while no event is pending, which pushes back on the receiver.
//   Output : four-phase. out_valid rises with the event fields already
//            stable. They stay stable until out_ack = 1. out_valid then drops,
//            and nothing new is accepted until out_ack returns to 0.
//
// Ports:
//   clock_25m, reset_25m_n : clock and asynchronous active-low reset
//   clock_valid            : clock enable; all registers freeze when it is 0
//   in_data/in_valid/in_ack: byte stream from the receiver
//   out_code/out_ext/out_release/out_valid/out_ack : event to the consumer
//   mods                   : {caps_lock, ralt, lalt, rctrl, lctrl, rshift, lshift}
//   overrun                : sticky, set by a 00 or FF byte
//   dbg_dec_state          : current decode FSM state
//   dbg_out_state          : current output FSM state
module ps2_keycode_decoder #(
   parameter int unsigned PAUSE_TAIL = 7
) (
   input  logic       clock_25m,
   input  logic       reset_25m_n,
   input  logic       clock_valid,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ack,
   output logic [7:0] out_code,
   output logic       out_ext,
   output logic       out_release,
   output logic       out_valid,
   input  logic       out_ack,
   output logic [6:0] mods,
   output logic       overrun,
   output logic [2:0] dbg_dec_state,
   output logic [1:0] dbg_out_state
);

   localparam int unsigned PW = (PAUSE_TAIL < 1) ? 1 : $clog2(PAUSE_TAIL + 1);
   localparam logic [PW-1:0] PAUSE_LOAD = PW'(PAUSE_TAIL);

   typedef enum logic [2:0] {
      D_IDLE  = 3'd0,
      D_E0    = 3'd1,
      D_F0    = 3'd2,
      D_E0F0  = 3'd3,
      D_PAUSE = 3'd4
   } dec_state_e;

   typedef enum logic [1:0] {
      O_EMPTY   = 2'd0,
      O_VALID   = 2'd1,
      O_WAITLOW = 2'd2
   } out_state_e;

   dec_state_e    dec_q, dec_d;
   out_state_e    out_q, out_d;
   logic [1:0]    hold_q, hold_d;
   logic [PW-1:0] pause_q, pause_d;
   logic          ack_q, ack_d;
   logic [7:0]    byte_q, byte_d;
   logic [7:0]    code_q, code_d;
   logic          ext_q, ext_d;
   logic          rel_q, rel_d;
   logic [6:0]    mods_q, mods_d;
   logic          caps_held_q, caps_held_d;
   logic          overrun_q, overrun_d;

   logic          accept;
   logic          emit;
   logic          emit_ext;
   logic          emit_rel;
   logic [7:0]    emit_code;

   always_comb begin
      dec_d       = dec_q;
      out_d       = out_q;
      hold_d      = hold_q;
      pause_d     = pause_q;
      byte_d      = byte_q;
      code_d      = code_q;
      ext_d       = ext_q;
      rel_d       = rel_q;
      mods_d      = mods_q;
      caps_held_d = caps_held_q;
      overrun_d   = overrun_q;
      emit        = 1'b0;
      emit_ext    = 1'b0;
      emit_rel    = 1'b0;
      emit_code   = byte_q;

      // ack_q also blocks acceptance, so the pulse can never be two cycles long.
      accept = in_valid && (hold_q == 2'd0) && (out_q == O_EMPTY) && !ack_q;
      ack_d  = accept;
      if (accept) begin
         byte_d = in_data;
         hold_d = 2'd2;
      end else if (hold_q != 2'd0) begin
         hold_d = hold_q - 2'd1;
      end

      // The byte captured with the in_ack pulse is decoded on the next edge.
      if (ack_q) begin
         case (dec_q)
            D_IDLE: begin
               case (byte_q)
                  8'hE0: dec_d = D_E0;
                  8'hF0: dec_d = D_F0;
                  8'hE1: begin
                     dec_d   = D_PAUSE;
                     pause_d = PAUSE_LOAD;
                  end
                  8'hAA, 8'hFA, 8'hEE, 8'hFE: ;
                  8'h00, 8'hFF: overrun_d = 1'b1;
                  default: emit = 1'b1;
               endcase
            end
            D_E0: begin
               dec_d = D_IDLE;
               if (byte_q == 8'hF0) begin
                  dec_d = D_E0F0;
               end else if (byte_q != 8'h12 && byte_q != 8'h59) begin
                  // 12/59 after E0 are fake shifts and carry no key.
                  emit     = 1'b1;
                  emit_ext = 1'b1;
               end
            end
            D_F0: begin
               dec_d    = D_IDLE;
               emit     = 1'b1;
               emit_rel = 1'b1;
            end
            D_E0F0: begin
               dec_d = D_IDLE;
               if (byte_q != 8'h12 && byte_q != 8'h59) begin
                  emit     = 1'b1;
                  emit_ext = 1'b1;
                  emit_rel = 1'b1;
               end
            end
            D_PAUSE: begin
               // The tail bytes are swallowed whatever their value.
               if (pause_q <= PW'(1)) begin
                  pause_d   = '0;
                  dec_d     = D_IDLE;
                  emit      = 1'b1;
                  emit_ext  = 1'b1;
                  emit_code = 8'hE1;
               end else begin
                  pause_d = pause_q - PW'(1);
               end
            end
            default: dec_d = D_IDLE;
         endcase
      end

      if (emit) begin
         code_d = emit_code;
         ext_d  = emit_ext;
         rel_d  = emit_rel;
         if (!emit_ext) begin
            case (emit_code)
               8'h12: mods_d[0] = !emit_rel;
               8'h59: mods_d[1] = !emit_rel;
               8'h14: mods_d[2] = !emit_rel;
               8'h11: mods_d[4] = !emit_rel;
               8'h58: begin
                  // caps_held stops typematic repeats from toggling caps lock again.
                  if (emit_rel) begin
                     caps_held_d = 1'b0;
                  end else begin
                     if (!caps_held_q) mods_d[6] = !mods_q[6];
                     caps_held_d = 1'b1;
                  end
               end
               default: ;
            endcase
         end else begin
            case (emit_code)
               8'h14: mods_d[3] = !emit_rel;
               8'h11: mods_d[5] = !emit_rel;
               default: ;
            endcase
         end
      end

      case (out_q)
         O_EMPTY:   if (emit) out_d = O_VALID;
         O_VALID:   if (out_ack) out_d = O_WAITLOW;
         O_WAITLOW: if (!out_ack) out_d = O_EMPTY;
         default:   out_d = O_EMPTY;
      endcase
   end

   always_ff @(posedge clock_25m or negedge reset_25m_n) begin
      if (!reset_25m_n) begin
         dec_q       <= D_IDLE;
         out_q       <= O_EMPTY;
         hold_q      <= 2'd0;
         pause_q     <= '0;
         ack_q       <= 1'b0;
         byte_q      <= 8'h00;
         code_q      <= 8'h00;
         ext_q       <= 1'b0;
         rel_q       <= 1'b0;
         mods_q      <= 7'h00;
         caps_held_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else if (clock_valid) begin
         dec_q       <= dec_d;
         out_q       <= out_d;
         hold_q      <= hold_d;
         pause_q     <= pause_d;
         ack_q       <= ack_d;
         byte_q      <= byte_d;
         code_q      <= code_d;
         ext_q       <= ext_d;
         rel_q       <= rel_d;
         mods_q      <= mods_d;
         caps_held_q <= caps_held_d;
         overrun_q   <= overrun_d;
      end
   end

   assign in_ack        = ack_q;
   assign out_valid     = (out_q == O_VALID);
   assign out_code      = code_q;
   assign out_ext       = ext_q;
   assign out_release   = rel_q;
   assign mods          = mods_q;
   assign overrun       = overrun_q;
   assign dbg_dec_state = dec_q;
   assign dbg_out_state = out_q;

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
module tb_ps2_keycode_decoder;

   logic       clk;
   logic       rst_n;
   logic       clock_valid;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ack;
   logic [7:0] out_code;
   logic       out_ext;
   logic       out_release;
   logic       out_valid;
   logic       out_ack;
   logic [6:0] mods;
   logic       overrun;
   logic [2:0] dbg_dec_state;
   logic [1:0] dbg_out_state;

   int checks = 0;
   int fails  = 0;
   int ack_count = 0;
   int event_count = 0;
   int ack_delay = 0;
   bit hold_ack = 0;
   bit prev_ack = 0;
   bit ov_prev = 0;

   // {code[16:9], ext[8], rel[7], mods[6:0]}
   logic [16:0] exp_q[$];

   ps2_keycode_decoder #(.PAUSE_TAIL(7)) dut (
      .clock_25m    (clk),
      .reset_25m_n  (rst_n),
      .clock_valid  (clock_valid),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ack       (in_ack),
      .out_code     (out_code),
      .out_ext      (out_ext),
      .out_release  (out_release),
      .out_valid    (out_valid),
      .out_ack      (out_ack),
      .mods         (mods),
      .overrun      (overrun),
      .dbg_dec_state(dbg_dec_state),
      .dbg_out_state(dbg_out_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #20 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic expect_ev(input logic [7:0] code, input logic ext, input logic rel,
                            input logic [6:0] m);
      exp_q.push_back({code, ext, rel, m});
   endtask

   // monitor: in_ack pulse shape and event scoreboard
   always @(negedge clk) begin
      if (in_ack) begin
         ack_count++;
         check("in_ack_single_cycle", {31'd0, prev_ack}, 32'd0);
      end
      prev_ack = in_ack;
      if (out_valid && !ov_prev) begin
         event_count++;
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_event: got code %0h ext %0b rel %0b, expected none",
                     out_code, out_ext, out_release);
         end else begin
            check("event", {15'd0, out_code, out_ext, out_release, mods}, {15'd0, exp_q.pop_front()});
         end
      end
      ov_prev = out_valid;
   end

   // consumer: four-phase acknowledge after ack_delay cycles
   initial begin
      int n;
      out_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid && !hold_ack) begin
            repeat (ack_delay) @(negedge clk);
            @(posedge clk);
            #1 out_ack = 1'b1;
            n = 0;
            while (out_valid && n < 20) begin
               @(negedge clk);
               n++;
            end
            check("out_valid_drops_on_ack", {31'd0, out_valid}, 32'd0);
            @(posedge clk);
            #1 out_ack = 1'b0;
         end
      end
   end

   // driver tasks
   task automatic present(input logic [7:0] b);
      @(posedge clk);
      #1;
      in_data  = b;
      in_valid = 1'b1;
   endtask

   task automatic wait_ack_drop();
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ack && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!in_ack) begin
         checks++;
         fails++;
         $display("FAIL in_ack_timeout: got no in_ack, expected one for byte %0h", in_data);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      present(b);
      wait_ack_drop();
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid || out_ack) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         fails++;
         $display("FAIL drain_timeout: got %0d events pending, expected 0", exp_q.size());
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int a0;
      int e0;
      rst_n       = 1'b0;
      clock_valid = 1'b1;
      in_data     = 8'h00;
      in_valid    = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_in_ack", {31'd0, in_ack}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_code", {24'd0, out_code}, 32'd0);
      check("rst_out_ext", {31'd0, out_ext}, 32'd0);
      check("rst_out_release", {31'd0, out_release}, 32'd0);
      check("rst_mods", {25'd0, mods}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single make code, consumer acks after 3 cycles, one-cycle latency
      ack_delay = 3;
      a0 = ack_count;
      expect_ev(8'h1C, 1'b0, 1'b0, 7'h00);
      present(8'h1C);
      wait_ack_drop();
      @(negedge clk);
      check("emit_latency", {31'd0, out_valid}, 32'd1);
      wait_idle();
      check("one_ack_for_one_byte", ack_count - a0, 32'd1);
      ack_delay = 0;

      // break
      expect_ev(8'h1C, 1'b0, 1'b1, 7'h00);
      send_byte(8'hF0);
      send_byte(8'h1C);
      wait_idle();

      // extended make and break
      expect_ev(8'h75, 1'b1, 1'b0, 7'h00);
      expect_ev(8'h75, 1'b1, 1'b1, 7'h00);
      send_byte(8'hE0); send_byte(8'h75);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      wait_idle();

      // modifiers
      e0 = event_count;
      expect_ev(8'h12, 1'b0, 1'b0, 7'h01);
      expect_ev(8'h12, 1'b0, 1'b0, 7'h01);
      expect_ev(8'h14, 1'b1, 1'b0, 7'h09);
      expect_ev(8'h12, 1'b0, 1'b1, 7'h08);
      send_byte(8'h12); send_byte(8'h12);
      send_byte(8'hE0); send_byte(8'h14);
      send_byte(8'hF0); send_byte(8'h12);
      wait_idle();
      check("mods_after_lshift_break", {25'd0, mods}, 32'h08);
      check("modifier_events", event_count - e0, 32'd4);

      // caps lock with typematic repeat
      expect_ev(8'h58, 1'b0, 1'b0, 7'h48);
      expect_ev(8'h58, 1'b0, 1'b0, 7'h48);
      expect_ev(8'h58, 1'b0, 1'b1, 7'h48);
      expect_ev(8'h58, 1'b0, 1'b0, 7'h08);
      send_byte(8'h58); send_byte(8'h58);
      send_byte(8'hF0); send_byte(8'h58);
      send_byte(8'h58);
      wait_idle();

      // pause sequence: one event after the eighth byte
      e0 = event_count;
      expect_ev(8'hE1, 1'b1, 1'b0, 7'h08);
      send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
      send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0);
      repeat (4) @(negedge clk);
      check("no_event_before_pause_end", event_count - e0, 32'd0);
      send_byte(8'h77);
      wait_idle();
      check("pause_single_event", event_count - e0, 32'd1);

      // backpressure while the consumer withholds out_ack
      hold_ack = 1;
      expect_ev(8'h1C, 1'b0, 1'b0, 7'h08);
      send_byte(8'h1C);
      a0 = ack_count;
      present(8'h2D);
      repeat (20) @(negedge clk);
      check("no_ack_while_pending", ack_count - a0, 32'd0);
      check("event_held", {31'd0, out_valid}, 32'd1);
      check("event_code_stable", {24'd0, out_code}, 32'h1C);
      expect_ev(8'h2D, 1'b0, 1'b0, 7'h08);
      hold_ack = 0;
      wait_ack_drop();
      wait_idle();

      // clock enable low freezes acceptance
      @(posedge clk);
      #1;
      clock_valid = 1'b0;
      in_data     = 8'h2E;
      in_valid    = 1'b1;
      a0 = ack_count;
      repeat (10) @(negedge clk);
      check("frozen_no_ack", ack_count - a0, 32'd0);
      expect_ev(8'h2E, 1'b0, 1'b0, 7'h08);
      clock_valid = 1'b1;
      wait_ack_drop();
      wait_idle();

      // dropped bytes and overrun
      e0 = event_count;
      send_byte(8'hFA);
      repeat (4) @(negedge clk);
      check("ack_byte_no_overrun", {31'd0, overrun}, 32'd0);
      send_byte(8'hFF);
      repeat (6) @(negedge clk);
      check("overrun_set", {31'd0, overrun}, 32'd1);
      check("dropped_no_event", event_count - e0, 32'd0);
      check("mods_kept", {25'd0, mods}, 32'h08);

      // reset in the middle of an E0 sequence
      send_byte(8'hE0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #5 rst_n = 1'b0;
      #2;
      check("midrst_overrun", {31'd0, overrun}, 32'd0);
      check("midrst_mods", {25'd0, mods}, 32'd0);
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      expect_ev(8'h1C, 1'b0, 1'b0, 7'h00);
      send_byte(8'h1C);
      wait_idle();

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
